// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared immediate format codes and XLEN legality check for imm_gen_pipe
package imm_gen_pkg;
  typedef enum logic [2:0] {
    IMM_ZERO  = 3'b000,
    IMM_I     = 3'b001,
    IMM_S     = 3'b010,
    IMM_B     = 3'b011,
    IMM_U     = 3'b100,
    IMM_J     = 3'b101,
    IMM_Z     = 3'b110,
    IMM_I_ALT = 3'b111
  } imm_type_e;
  localparam int XLEN_NARROW = 32;
  localparam int XLEN_WIDE   = 64;
  function automatic bit xlen_legal(input int xlen);
    return xlen == XLEN_NARROW || xlen == XLEN_WIDE;
  endfunction
endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational RISC-V immediate decode, sign-extended from bit 31 to XLEN
// Ports: instr[31:7] instruction bits, typ format select, imm extended result,
//        err set when the format code is unsupported in this build.
// Build option: IMM_GEN_ZIMM_EN enables the CSR zimm format (code 110).
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_type_e       typ,
  output logic [XLEN-1:0] imm,
  output logic            err
);
  logic [31:0] w_imm32;
  logic [31:0] w_imm_i;
  assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
  // Every format is already correct in 32 bits with bit 31 as its sign (zimm and zero have bit 31 clear),
  // so one sign extension covers XLEN=64, including the U format.
  always_comb begin
    w_imm32 = '0;
    err = 1'b0;
    case (typ)
      IMM_ZERO:         w_imm32 = '0;
      IMM_I, IMM_I_ALT: w_imm32 = w_imm_i;
      IMM_S:            w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:            w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:            w_imm32 = {instr[31:12], 12'h000};
      IMM_J:            w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      IMM_Z:            w_imm32 = {27'b0, instr[19:15]};
`else
      IMM_Z: begin
        w_imm32 = w_imm_i;
        err = 1'b1;
      end
`endif
    endcase
  end
  assign imm = XLEN'($signed(w_imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with valid/ready handshake and 2-entry skid buffer
// Ports: clk, rst (sync, active high), flush (sync discard);
//        in_valid/in_ready, instr_in, imm_type_in, tag_in upstream;
//        out_valid/out_ready, imm_out, tag_out, type_err downstream.
// Build option: IMM_GEN_ZIMM_EN (see imm_decode_comb).
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:7]      instr_in,
  input  logic [2:0]       imm_type_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             type_err
);
  localparam bit XLEN_OK = xlen_legal(XLEN);
  if (!XLEN_OK) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  logic             r_main_v, r_skid_v;
  logic [XLEN-1:0]  r_main_imm, r_skid_imm;
  logic [TAG_W-1:0] r_main_tag, r_skid_tag;
  logic             r_main_err, r_skid_err;
  logic [XLEN-1:0]  w_imm;
  logic             w_err, w_acc;
  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr(instr_in),
    .typ  (imm_type_e'(imm_type_in)),
    .imm  (w_imm),
    .err  (w_err)
  );
  // Ready depends only on the skid flag, so out_ready never reaches in_ready combinationally.
  assign in_ready  = !r_skid_v;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = r_main_v;
  assign imm_out   = r_main_imm;
  assign tag_out   = r_main_tag;
  assign type_err  = r_main_err;
  // Main can advance when empty or emitting; skid is only ever full while main is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_v   <= 1'b0;
      r_main_imm <= '0;
      r_main_tag <= '0;
      r_main_err <= 1'b0;
      r_skid_v   <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_err <= 1'b0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || out_ready) begin
      r_main_v <= r_skid_v || w_acc;
      r_skid_v <= 1'b0;
      if (r_skid_v) begin
        r_main_imm <= r_skid_imm;
        r_main_tag <= r_skid_tag;
        r_main_err <= r_skid_err;
      end else if (w_acc) begin
        r_main_imm <= w_imm;
        r_main_tag <= tag_in;
        r_main_err <= w_err;
      end
    end else if (w_acc) begin
      r_skid_v   <= 1'b1;
      r_skid_imm <= w_imm;
      r_skid_tag <= tag_in;
      r_skid_err <= w_err;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving XLEN=32 and XLEN=64 instances with shared directed stimulus
module tb_imm_gen_pipe;
  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag;
    logic        err;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:7] instr_in;
  logic [2:0]  imm_type_in;
  logic [7:0]  tag_in;
  logic        in_ready32, out_valid32, type_err32;
  logic [31:0] imm_out32;
  logic [7:0]  tag_out32;
  logic        in_ready64, out_valid64, type_err64;
  logic [63:0] imm_out64;
  logic [7:0]  tag_out64;
  int          checks = 0;
  int          errors = 0;
  exp_t        cur;
  exp_t        q32[$];
  exp_t        q64[$];
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
    .out_valid(out_valid32), .out_ready(out_ready), .imm_out(imm_out32),
    .tag_out(tag_out32), .type_err(type_err32)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr_in(instr_in), .imm_type_in(imm_type_in), .tag_in(tag_in),
    .out_valid(out_valid64), .out_ready(out_ready), .imm_out(imm_out64),
    .tag_out(tag_out64), .type_err(type_err64)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // Expected entry enters the scoreboard only on a real accept (flush and reset drop it).
  always @(posedge clk) begin
    if (!rst && !flush && in_valid && in_ready32) begin
      q32.push_back(cur);
      q64.push_back(cur);
    end
  end
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected32: got tag %0d expected no output", tag_out32);
      end else begin
        e = q32.pop_front();
        chk("imm32", 64'(imm_out32), e.imm32);
        chk("tag32", 64'(tag_out32), 64'(e.tag));
        chk("err32", 64'(type_err32), 64'(e.err));
      end
    end
  end
  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected64: got tag %0d expected no output", tag_out64);
      end else begin
        e = q64.pop_front();
        chk("imm64", imm_out64, e.imm64);
        chk("tag64", 64'(tag_out64), 64'(e.tag));
        chk("err64", 64'(type_err64), 64'(e.err));
      end
    end
  end
  task automatic drive(input logic [2:0] ty, input logic [31:0] ins, input logic [7:0] tg,
                       input logic [63:0] e32, input logic [63:0] e64, input logic er);
    imm_type_in = ty;
    instr_in = ins[31:7];
    tag_in = tg;
    cur = '{e32, e64, tg, er};
    in_valid = 1'b1;
  endtask
  task automatic send(input logic [2:0] ty, input logic [31:0] ins, input logic [7:0] tg,
                      input logic [63:0] e32, input logic [63:0] e64, input logic er);
    bit ok = 1'b0;
    drive(ty, ins, tg, e32, e64, er);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready32;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %0d in_ready stayed 0, expected 1", tg);
    end
  endtask
  task automatic send_i(input logic [7:0] tg);
    send(3'b001, (32'(tg) << 20) | 32'h93, tg, 64'(tg), 64'(tg), 1'b0);
  endtask
  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid32), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready32), 64'd1);
    chk({tag, "_imm32"}, 64'(imm_out32), 64'd0);
    chk({tag, "_tag"}, 64'(tag_out32), 64'd0);
    chk({tag, "_err"}, 64'(type_err32), 64'd0);
    chk({tag, "_imm64"}, imm_out64, 64'd0);
    chk({tag, "_out_valid64"}, 64'(out_valid64), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    logic [2:0]  vt[9];
    logic [31:0] vi[9];
    logic [63:0] v32[9];
    logic [63:0] v64[9];
    logic        ve[9];
    vt[0] = 3'b001; vi[0] = 32'hFFF00093; v32[0] = 64'hFFFFFFFF;         v64[0] = 64'hFFFFFFFFFFFFFFFF; ve[0] = 0;
    vt[1] = 3'b011; vi[1] = 32'hFE000EE3; v32[1] = 64'hFFFFFFFC;         v64[1] = 64'hFFFFFFFFFFFFFFFC; ve[1] = 0;
    vt[2] = 3'b100; vi[2] = 32'h123450B7; v32[2] = 64'h12345000;         v64[2] = 64'h0000000012345000; ve[2] = 0;
    vt[3] = 3'b100; vi[3] = 32'h800000B7; v32[3] = 64'h80000000;         v64[3] = 64'hFFFFFFFF80000000; ve[3] = 0;
    vt[4] = 3'b010; vi[4] = 32'h00A12423; v32[4] = 64'h8;                v64[4] = 64'h8;                ve[4] = 0;
    vt[5] = 3'b101; vi[5] = 32'hFFDFF06F; v32[5] = 64'hFFFFFFFC;         v64[5] = 64'hFFFFFFFFFFFFFFFC; ve[5] = 0;
    vt[6] = 3'b000; vi[6] = 32'hFFFFFFFF; v32[6] = 64'h0;                v64[6] = 64'h0;                ve[6] = 0;
    vt[7] = 3'b111; vi[7] = 32'h7FF00013; v32[7] = 64'h7FF;              v64[7] = 64'h7FF;              ve[7] = 0;
`ifdef IMM_GEN_ZIMM_EN
    vt[8] = 3'b110; vi[8] = 32'h800AF073; v32[8] = 64'h15;               v64[8] = 64'h15;               ve[8] = 0;
`else
    vt[8] = 3'b110; vi[8] = 32'h800AF073; v32[8] = 64'hFFFFF800;         v64[8] = 64'hFFFFFFFFFFFFF800; ve[8] = 1;
`endif
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(3'b001, 32'hFFF00093, 8'hEE, 64'h0, 64'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    // Back-to-back directed formats with downstream always ready.
    for (int i = 0; i < 9; i++) begin
      send(vt[i], vi[i], 8'(10 + i), v32[i], v64[i], ve[i]);
      if (i == 0) begin
        chk("latency_valid", 64'(out_valid32), 64'd1);
        chk("latency_tag", 64'(tag_out32), 64'd10);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_formats", 64'(q32.size()), 64'd0);
    // Stall for 3 cycles after tag 1 while streaming tags 1..4.
    send_i(8'd1);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    send_i(8'd2);
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready32), 64'd0);
    chk("stall_hold_tag", 64'(tag_out32), 64'd1);
    chk("stall_hold_imm", 64'(imm_out32), 64'd1);
    send_i(8'd3);
    send_i(8'd4);
    repeat (4) @(posedge clk);
    #1;
    chk("drain_stream", 64'(q32.size()), 64'd0);
    // Flush with both entries full and a pending input.
    out_ready = 1'b0;
    send_i(8'd20);
    send_i(8'd21);
    chk("full_in_ready", 64'(in_ready32), 64'd0);
    drive(3'b001, 32'h01600093, 8'd22, 64'd22, 64'd22, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    chk("flush_full_valid", 64'(out_valid32), 64'd0);
    chk("flush_full_ready", 64'(in_ready32), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Flush drops a same-cycle accept when there is room.
    out_ready = 1'b0;
    send_i(8'd30);
    drive(3'b001, 32'h01F00093, 8'd31, 64'd31, 64'd31, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    chk("flush_acc_valid", 64'(out_valid32), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send_i(8'd32);
    // Emit coinciding with flush still completes.
    send_i(8'd40);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_emit_done", 64'(q32.size()), 64'd0);
    chk("flush_emit_valid", 64'(out_valid32), 64'd0);
    // Reset mid-stall with both entries full.
    out_ready = 1'b0;
    send_i(8'd50);
    send_i(8'd51);
    drive(3'b001, 32'h03400093, 8'd52, 64'd52, 64'd52, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    q32.delete(); q64.delete();
    @(negedge clk);
    check_reset_state("midreset");
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_i(8'd53);
    chk("post_reset_valid", 64'(out_valid32), 64'd1);
    chk("post_reset_tag", 64'(tag_out32), 64'd53);
    repeat (4) @(posedge clk);
    #1;
    chk("final_q32", 64'(q32.size()), 64'd0);
    chk("final_q64", 64'(q64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
